// File: rtl/pwm_duty_sched_if.sv
// Request bundle for pwm_duty_sched: NREQ requesters, each presenting a (channel, duty) pair.
// The master modport is the requester side; the slave modport is the scheduler side.
interface pwm_duty_sched_if #(
  parameter int unsigned NREQ = 2,
  parameter int unsigned NCH  = 4,
  parameter int unsigned W    = 12
);
  localparam int unsigned CW = $clog2(NCH);

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*CW-1:0] req_chan;
  logic [NREQ*W-1:0]  req_duty;
  logic [NREQ-1:0]    req_ready;

  modport master (output req_valid, output req_chan, output req_duty, input req_ready);
  modport slave  (input req_valid, input req_chan, input req_duty, output req_ready);
endinterface

// File: rtl/pwm_duty_sched.sv
// Round-robin scheduler of PWM duty updates: accepted requests land in per-channel shadows
// and are committed to the active compare outputs only at the period boundary (Ctr_0).
module pwm_duty_sched #(
  parameter int unsigned NCH        = 4,
  parameter int unsigned NREQ       = 2,
  parameter int unsigned W          = 12,
  parameter int unsigned PERIOD_MAX = 999
) (
  input  logic             Clock,
  input  logic             Rst,
  input  logic             Ctr_0,
  input  logic             Hold,
  pwm_duty_sched_if.slave  req,
  output logic [NCH*W-1:0] Duty_o,
  output logic [NCH-1:0]   Duty_ld,
  output logic [NCH-1:0]   Pending,
  output logic             Clip
);
  localparam int unsigned CW = $clog2(NCH);
  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [W-1:0] DutyMax = W'(PERIOD_MAX);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d, win_q, win_d, sel;
  logic            sel_found;
  logic [NREQ-1:0] ready_q, ready_d;
  logic [W-1:0]    shadow_q [NCH];
  logic [W-1:0]    shadow_d [NCH];
  logic [W-1:0]    duty_q [NCH];
  logic [W-1:0]    duty_d [NCH];
  logic [NCH-1:0]  pend_q, pend_d, ld_q, ld_d;
  logic            clip_q, clip_d;
  logic [CW-1:0]   win_chan;
  logic [W-1:0]    win_duty;

  assign win_chan = req.req_chan[int'(win_q)*CW +: CW];
  assign win_duty = req.req_duty[int'(win_q)*W +: W];

  // First valid requester at or after the pointer, wrapping.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    sel       = '0;
    sel_found = 1'b0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      idx = (int'(ptr_q) + i) % NREQ;
      if (!sel_found && req.req_valid[idx[PW-1:0]]) begin
        sel_found = 1'b1;
        sel       = idx[PW-1:0];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    win_d    = win_q;
    ready_d  = '0;
    shadow_d = shadow_q;
    duty_d   = duty_q;
    pend_d   = pend_q;
    ld_d     = '0;
    clip_d   = 1'b0;

    if (Ctr_0 && !Hold) begin
      for (int unsigned c = 0; c < NCH; c++) begin
        if (pend_q[c]) begin
          duty_d[c] = shadow_q[c];
          ld_d[c]   = 1'b1;
          pend_d[c] = 1'b0;
        end
      end
    end

    // The grant write follows the commit so a colliding write stays pending.
    unique case (state_q)
      StIdle: begin
        if (sel_found) begin
          win_d        = sel;
          ready_d[sel] = 1'b1;
          state_d      = StGrant;
        end
      end
      StGrant: begin
        state_d = StIdle;
        ptr_d   = (win_q == PW'(NREQ - 1)) ? '0 : win_q + PW'(1);
        if (req.req_valid[win_q]) begin
          shadow_d[win_chan] = (win_duty > DutyMax) ? DutyMax : win_duty;
          pend_d[win_chan]   = 1'b1;
          clip_d             = (win_duty > DutyMax);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clock or posedge Rst) begin
    if (Rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      win_q   <= '0;
      ready_q <= '0;
      pend_q  <= '0;
      ld_q    <= '0;
      clip_q  <= 1'b0;
      for (int unsigned c = 0; c < NCH; c++) begin
        shadow_q[c] <= '0;
        duty_q[c]   <= '0;
      end
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      win_q    <= win_d;
      ready_q  <= ready_d;
      pend_q   <= pend_d;
      ld_q     <= ld_d;
      clip_q   <= clip_d;
      shadow_q <= shadow_d;
      duty_q   <= duty_d;
    end
  end

  always_comb begin
    Duty_o = '0;
    for (int unsigned c = 0; c < NCH; c++) Duty_o[c*W +: W] = duty_q[c];
  end

  assign req.req_ready = ready_q;
  assign Duty_ld       = ld_q;
  assign Pending       = pend_q;
  assign Clip          = clip_q;
endmodule

// File: tb/tb_pwm_duty_sched.sv
// Bench for pwm_duty_sched: directed scenarios with constant expectations, then a randomized
// run checked cycle by cycle against a behavioural model of the scheduling rules.
module tb_pwm_duty_sched;
  localparam int NCH = 4, NREQ = 2, W = 12, CW = 2, PMAX = 999;

  logic             Clock = 1'b0;
  logic             Rst, Ctr_0, Hold;
  logic [NCH*W-1:0] Duty_o;
  logic [NCH-1:0]   Duty_ld, Pending;
  logic             Clip;
  int               checks = 0, failures = 0;

  pwm_duty_sched_if #(.NREQ(NREQ), .NCH(NCH), .W(W)) ifc ();

  pwm_duty_sched #(.NCH(NCH), .NREQ(NREQ), .W(W), .PERIOD_MAX(PMAX)) dut (
    .Clock  (Clock),
    .Rst    (Rst),
    .Ctr_0  (Ctr_0),
    .Hold   (Hold),
    .req    (ifc.slave),
    .Duty_o (Duty_o),
    .Duty_ld(Duty_ld),
    .Pending(Pending),
    .Clip   (Clip)
  );

  always #5 Clock = ~Clock;

  // Behavioural model: shadows, pending flags, active values, one grant per two cycles.
  logic [W-1:0]    m_shadow [NCH];
  logic [W-1:0]    m_duty [NCH];
  logic [NCH-1:0]  m_pend, m_ld;
  logic [NREQ-1:0] m_ready;
  logic            m_clip;
  int              m_ptr, m_win;
  bit              m_busy;

  task automatic model_step();
    int ch, d, r;
    if (Rst) begin
      for (int c = 0; c < NCH; c++) begin m_shadow[c] = '0; m_duty[c] = '0; end
      m_pend = '0; m_ld = '0; m_ready = '0; m_clip = 1'b0; m_ptr = 0; m_win = 0; m_busy = 0;
      return;
    end
    m_ld = '0;
    m_clip = 1'b0;
    if (Ctr_0 && !Hold)
      for (int c = 0; c < NCH; c++)
        if (m_pend[c]) begin m_duty[c] = m_shadow[c]; m_ld[c] = 1'b1; m_pend[c] = 1'b0; end
    m_ready = '0;
    if (m_busy) begin
      m_busy = 0;
      if (ifc.req_valid[m_win]) begin
        ch = int'(ifc.req_chan[m_win*CW +: CW]);
        d  = int'(ifc.req_duty[m_win*W +: W]);
        m_shadow[ch] = W'((d > PMAX) ? PMAX : d);
        m_pend[ch]   = 1'b1;
        m_clip       = (d > PMAX);
      end
      m_ptr = (m_win + 1) % NREQ;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        r = (m_ptr + k) % NREQ;
        if (!m_busy && ifc.req_valid[r]) begin m_busy = 1; m_win = r; m_ready[r] = 1'b1; end
      end
    end
  endtask

  initial forever begin
    @(posedge Clock or posedge Rst);
    model_step();
  end

  function automatic int duty_of(input int c);
    return int'(Duty_o[c*W +: W]);
  endfunction

  task automatic tick();
    @(negedge Clock);
  endtask

  task automatic pulse_ctr();
    Ctr_0 = 1'b1;
    tick();
    Ctr_0 = 1'b0;
  endtask

  // Present a request and return at the negedge after the accept edge.
  task automatic do_req(input int r, input int ch, input int d);
    int n;
    ifc.req_valid[r]           = 1'b1;
    ifc.req_chan[r*CW +: CW]   = CW'(ch);
    ifc.req_duty[r*W +: W]     = W'(d);
    n = 0;
    do begin tick(); n++; end while (!ifc.req_ready[r] && n < 20);
    if (!ifc.req_ready[r]) begin
      checks++; failures++;
      $display("FAIL do_req_timeout r=%0d: ready never seen, required within 20 cycles", r);
    end
    tick();
    ifc.req_valid[r] = 1'b0;
  endtask

  task automatic test_reset();
    Rst = 1'b1; Ctr_0 = 1'b0; Hold = 1'b0;
    ifc.req_valid = '0; ifc.req_chan = '0; ifc.req_duty = '0;
    tick(); tick();
    checks++; if (Duty_o !== '0) begin failures++; $display("FAIL reset_duty got=%h want=0", Duty_o); end
    checks++; if (Pending !== '0) begin failures++; $display("FAIL reset_pending got=%b want=0", Pending); end
    checks++; if (Duty_ld !== '0) begin failures++; $display("FAIL reset_ld got=%b want=0", Duty_ld); end
    checks++; if (ifc.req_ready !== '0 || Clip !== 1'b0) begin
      failures++; $display("FAIL reset_ready_clip got=%b/%b want=00/0", ifc.req_ready, Clip);
    end
    Rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    do_req(0, 2, 500);
    checks++; if (Pending !== 4'b0100) begin failures++; $display("FAIL single_pending got=%b want=0100", Pending); end
    repeat (8) tick();
    pulse_ctr();
    checks++; if (duty_of(2) !== 500) begin failures++; $display("FAIL single_duty got=%0d want=500", duty_of(2)); end
    checks++; if (Duty_ld !== 4'b0100) begin failures++; $display("FAIL single_ld got=%b want=0100", Duty_ld); end
    checks++; if (Pending !== 4'b0000) begin failures++; $display("FAIL single_clear got=%b want=0000", Pending); end
    tick();
    checks++; if (Duty_ld !== 4'b0000) begin failures++; $display("FAIL single_ld_width got=%b want=0000", Duty_ld); end
  endtask

  task automatic test_fairness();
    logic [NREQ-1:0] exp_rdy [8];
    exp_rdy = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
    Rst = 1'b1; tick(); Rst = 1'b0;
    ifc.req_chan = {2'd1, 2'd0};
    ifc.req_duty = {12'd200, 12'd100};
    ifc.req_valid = 2'b11;
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++;
      if (ifc.req_ready !== exp_rdy[i]) begin
        failures++; $display("FAIL fair_grant[%0d] got=%b want=%b", i, ifc.req_ready, exp_rdy[i]);
      end
    end
    ifc.req_valid = '0;
    tick();
    pulse_ctr();
    checks++; if (duty_of(0) !== 100 || duty_of(1) !== 200) begin
      failures++; $display("FAIL fair_duty got=%0d/%0d want=100/200", duty_of(0), duty_of(1));
    end
  endtask

  task automatic test_clip();
    do_req(0, 2, 999);
    checks++; if (Clip !== 1'b0) begin failures++; $display("FAIL clip_boundary got=%b want=0", Clip); end
    do_req(1, 3, 4000);
    checks++; if (Clip !== 1'b1) begin failures++; $display("FAIL clip_pulse got=%b want=1", Clip); end
    tick();
    checks++; if (Clip !== 1'b0) begin failures++; $display("FAIL clip_width got=%b want=0", Clip); end
    pulse_ctr();
    checks++; if (duty_of(3) !== 999 || duty_of(2) !== 999) begin
      failures++; $display("FAIL clip_duty got=%0d/%0d want=999/999", duty_of(2), duty_of(3));
    end
  endtask

  task automatic test_collision();
    int n;
    do_req(0, 1, 150);
    ifc.req_valid[1] = 1'b1; ifc.req_chan[CW +: CW] = 2'd1; ifc.req_duty[W +: W] = 12'd300;
    n = 0;
    do begin tick(); n++; end while (!ifc.req_ready[1] && n < 20);
    Ctr_0 = 1'b1;
    tick();
    Ctr_0 = 1'b0; ifc.req_valid[1] = 1'b0;
    checks++; if (duty_of(1) !== 150) begin failures++; $display("FAIL coll_old got=%0d want=150", duty_of(1)); end
    checks++; if (Pending[1] !== 1'b1 || Duty_ld[1] !== 1'b1) begin
      failures++; $display("FAIL coll_pend got=%b/%b want=1/1", Pending[1], Duty_ld[1]);
    end
    tick();
    pulse_ctr();
    checks++; if (duty_of(1) !== 300 || Pending !== '0) begin
      failures++; $display("FAIL coll_new got=%0d/%b want=300/0000", duty_of(1), Pending);
    end
  endtask

  task automatic test_hold();
    do_req(0, 0, 77);
    Hold = 1'b1;
    pulse_ctr();
    Hold = 1'b0;
    checks++; if (Duty_ld !== '0 || duty_of(0) !== 100) begin
      failures++; $display("FAIL hold_nocommit got=%b/%0d want=0000/100", Duty_ld, duty_of(0));
    end
    checks++; if (Pending !== 4'b0001) begin failures++; $display("FAIL hold_pending got=%b want=0001", Pending); end
    tick();
    pulse_ctr();
    checks++; if (duty_of(0) !== 77 || Duty_ld !== 4'b0001) begin
      failures++; $display("FAIL hold_commit got=%0d/%b want=77/0001", duty_of(0), Duty_ld);
    end
  endtask

  task automatic test_reset_mid();
    do_req(0, 1, 5);
    ifc.req_chan = {2'd2, 2'd3};
    ifc.req_valid = 2'b11;
    tick();
    Rst = 1'b1;
    #1;
    checks++; if (ifc.req_ready !== '0 || Pending !== '0 || Duty_o !== '0) begin
      failures++; $display("FAIL rst_mid got=%b/%b/%h want=00/0000/0", ifc.req_ready, Pending, Duty_o);
    end
    tick();
    Rst = 1'b0;
    tick();
    checks++; if (ifc.req_ready !== 2'b01) begin failures++; $display("FAIL rst_first_grant got=%b want=01", ifc.req_ready); end
    ifc.req_valid = '0;
    tick(); tick();
  endtask

  task automatic test_random();
    logic [NREQ-1:0] acc;
    logic [NCH*W-1:0] exp_duty;
    acc = '0;
    Rst = 1'b1; tick(); Rst = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      for (int c = 0; c < NCH; c++) exp_duty[c*W +: W] = m_duty[c];
      checks++; if (ifc.req_ready !== m_ready) begin
        failures++; $display("FAIL rnd_ready cyc=%0d got=%b want=%b", cyc, ifc.req_ready, m_ready);
      end
      checks++; if (Duty_o !== exp_duty) begin
        failures++; $display("FAIL rnd_duty cyc=%0d got=%h want=%h", cyc, Duty_o, exp_duty);
      end
      checks++; if (Duty_ld !== m_ld || Pending !== m_pend) begin
        failures++; $display("FAIL rnd_ld_pend cyc=%0d got=%b/%b want=%b/%b", cyc, Duty_ld, Pending, m_ld, m_pend);
      end
      checks++; if (Clip !== m_clip) begin
        failures++; $display("FAIL rnd_clip cyc=%0d got=%b want=%b", cyc, Clip, m_clip);
      end
      for (int r = 0; r < NREQ; r++) begin
        if (acc[r]) ifc.req_valid[r] = 1'b0;
        acc[r] = ifc.req_ready[r];
        if (acc[r] && $urandom_range(7) == 0) ifc.req_valid[r] = 1'b0;
        if (!ifc.req_valid[r] && !acc[r] && $urandom_range(2) == 0) begin
          ifc.req_chan[r*CW +: CW] = CW'($urandom_range(NCH - 1));
          ifc.req_duty[r*W +: W]   = W'($urandom_range(1) ? $urandom_range(PMAX) : $urandom_range(4095));
          ifc.req_valid[r]         = 1'b1;
        end
      end
      Ctr_0 = ($urandom_range(4) == 0);
      Hold  = ($urandom_range(3) == 0);
      Rst   = ($urandom_range(199) == 0);
      if (Rst) begin ifc.req_valid = '0; acc = '0; end
      tick();
    end
    Rst = 1'b0; Ctr_0 = 1'b0; Hold = 1'b0; ifc.req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_clip();
    test_collision();
    test_hold();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
